yuv_transform_scheduler: RTL and testbench

- Shares one pipelined RGB-to-YCbCr colour-transform datapath between NUM_REQ independent pixel streams, e.g. several camera or line-buffer channels feeding the coder.
- Arbitrates round-robin at packet granularity. A grant holds from the sop beat through the eop beat.
- Forwards accepted beats into the datapath and tags every in-flight beat with its requester ID in a latency-matched pipe.
- Steers the datapath output back to the owning requester.

---
 rtl/yuv_transform_scheduler.sv | 172 +++++++++++++++++
 tb/tb_yuv_transform_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv_transform_scheduler.sv
// yuv_transform_scheduler
// Shares one fixed-latency RGB-to-YCbCr datapath between NUM_REQ pixel
// streams. A round-robin arbiter grants the datapath to one packet at a time.
// A latency-matched tag pipe then returns each result to the requester that owns it.
module yuv_transform_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 10,
    parameter int PIPE_LAT   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ-1:0]                 req_sop,
    input  logic [NUM_REQ-1:0]                 req_eop,
    output logic                               dp_in_valid,
    output logic [3*DATA_WIDTH-1:0]            dp_in_data,
    output logic                               dp_in_sop,
    output logic                               dp_in_eop,
    input  logic [3*DATA_WIDTH-1:0]            dp_out_data,
    output logic [NUM_REQ-1:0]                 out_valid,
    output logic [3*DATA_WIDTH-1:0]            out_data,
    output logic                               out_sop,
    output logic                               out_eop,
    output logic [$clog2(NUM_REQ)-1:0]         out_id,
    output logic                               busy,
    output logic                               sop_err
);

    localparam int IdW  = $clog2(NUM_REQ);
    localparam int PixW = 3 * DATA_WIDTH;

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t           state_q;
    logic [IdW-1:0]   grantId_q;
    logic [IdW-1:0]   grantId_d;
    logic [IdW-1:0]   rrPtr_q;
    logic             firstBeat_q;
    logic             anyReq;
    logic [IdW-1:0]   cand;

    logic             selValid;
    logic             selSop;
    logic             selEop;
    logic [PixW-1:0]  selData;
    logic             accept;
    logic             sopBad;
    logic             anyTag;

    logic             tagV_q   [PIPE_LAT];
    logic             tagSop_q [PIPE_LAT];
    logic             tagEop_q [PIPE_LAT];
    logic [IdW-1:0]   tagId_q  [PIPE_LAT];

    // Round-robin pick: first valid requester after the last packet owner
    always_comb begin
        anyReq    = 1'b0;
        grantId_d = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IdW'((int'(rrPtr_q) + off) % NUM_REQ);
            if (!anyReq && req_valid[cand]) begin
                anyReq    = 1'b1;
                grantId_d = cand;
            end
        end
    end

    // Select the granted requester's beat and build the per-requester readies
    always_comb begin
        selValid  = 1'b0;
        selSop    = 1'b0;
        selEop    = 1'b0;
        selData   = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grantId_q == IdW'(k)) begin
                selValid = req_valid[k];
                selSop   = req_sop[k];
                selEop   = req_eop[k];
                selData  = req_data[k*PixW +: PixW];
                req_ready[k] = (state_q == LOCK);
            end
        end
    end

    // Accept handshake; a first beat without sop is swallowed and flagged
    always_comb begin
        accept      = (state_q == LOCK) && selValid;
        sopBad      = accept && firstBeat_q && !selSop;
        dp_in_valid = accept && !sopBad;
        dp_in_data  = selData;
        dp_in_sop   = selSop;
        dp_in_eop   = selEop;
        sop_err     = sopBad;
    end

    // Arbitration / packet-lock state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grantId_q   <= '0;
            rrPtr_q     <= IdW'(NUM_REQ - 1);
            firstBeat_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        grantId_q   <= grantId_d;
                        firstBeat_q <= 1'b1;
                        state_q     <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        firstBeat_q <= 1'b0;
                        if (selEop) begin
                            state_q <= IDLE;
                            rrPtr_q <= grantId_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag pipe that follows each forwarded beat through the datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tagV_q[i]   <= 1'b0;
                tagSop_q[i] <= 1'b0;
                tagEop_q[i] <= 1'b0;
                tagId_q[i]  <= '0;
            end
        end else begin
            tagV_q[0]   <= dp_in_valid;
            tagSop_q[0] <= dp_in_sop;
            tagEop_q[0] <= dp_in_eop;
            tagId_q[0]  <= grantId_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tagV_q[i]   <= tagV_q[i-1];
                tagSop_q[i] <= tagSop_q[i-1];
                tagEop_q[i] <= tagEop_q[i-1];
                tagId_q[i]  <= tagId_q[i-1];
            end
        end
    end

    // Steer the datapath result to its owner and report activity
    always_comb begin
        anyTag = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            anyTag = anyTag | tagV_q[i];
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            out_valid[k] = tagV_q[PIPE_LAT-1] && (tagId_q[PIPE_LAT-1] == IdW'(k));
        end
        out_sop  = tagV_q[PIPE_LAT-1] & tagSop_q[PIPE_LAT-1];
        out_eop  = tagV_q[PIPE_LAT-1] & tagEop_q[PIPE_LAT-1];
        out_id   = tagId_q[PIPE_LAT-1];
        out_data = dp_out_data;
        busy     = (state_q == LOCK) || anyTag;
    end

endmodule

// File: tb/tb_yuv_transform_scheduler.sv
// Bench for yuv_transform_scheduler. Each cycle is one table vector of
// requester inputs plus hand-computed outputs. The bench ends with a
// hand-written sequence that resets the design in the middle of a packet.
// The datapath is modelled as an identity function with a fixed 3-cycle delay.
module tb_yuv_transform_scheduler;

    localparam int NR  = 4;
    localparam int DW  = 10;
    localparam int LAT = 3;
    localparam int PW  = 3 * DW;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*PW-1:0] req_data;
    logic [NR-1:0]   req_sop;
    logic [NR-1:0]   req_eop;
    logic            dp_in_valid;
    logic [PW-1:0]   dp_in_data;
    logic            dp_in_sop;
    logic            dp_in_eop;
    logic [PW-1:0]   dp_out_data;
    logic [NR-1:0]   out_valid;
    logic [PW-1:0]   out_data;
    logic            out_sop;
    logic            out_eop;
    logic [1:0]      out_id;
    logic            busy;
    logic            sop_err;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  sop;
        logic [3:0]  eop;
        logic [7:0]  pix;
        logic [3:0]  expReady;
        logic        expDpv;
        logic        expDps;
        logic        expDpe;
        logic [29:0] expDpData;
        logic [3:0]  expOutV;
        logic        expOutSop;
        logic        expOutEop;
        logic [1:0]  expOutId;
        logic [29:0] expOutData;
        logic        expSopErr;
        logic        expBusy;
    } vec_t;

    vec_t vecs[$];
    logic [PW-1:0] dpPipe [LAT];

    yuv_transform_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_sop(req_sop), .req_eop(req_eop),
        .dp_in_valid(dp_in_valid), .dp_in_data(dp_in_data),
        .dp_in_sop(dp_in_sop), .dp_in_eop(dp_in_eop),
        .dp_out_data(dp_out_data),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .out_id(out_id), .busy(busy), .sop_err(sop_err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Identity datapath with a LAT-cycle delay
    always @(posedge clk) begin
        dpPipe[0] <= dp_in_data;
        for (int i = 1; i < LAT; i++) dpPipe[i] <= dpPipe[i-1];
    end
    assign dp_out_data = dpPipe[LAT-1];

    task automatic addVec(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                          input logic [7:0] pix, input logic [3:0] rdy, input logic dpv,
                          input logic dps, input logic dpe, input logic [29:0] dpd,
                          input logic [3:0] ov, input logic os, input logic oe,
                          input logic [1:0] oid, input logic [29:0] od,
                          input logic serr, input logic bsy);
        vec_t t;
        t.valid = v; t.sop = s; t.eop = e; t.pix = pix;
        t.expReady = rdy; t.expDpv = dpv; t.expDps = dps; t.expDpe = dpe; t.expDpData = dpd;
        t.expOutV = ov; t.expOutSop = os; t.expOutEop = oe; t.expOutId = oid; t.expOutData = od;
        t.expSopErr = serr; t.expBusy = bsy;
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs just after the rising edge; requester k sends k*256+pix
    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] s,
                                 input logic [3:0] e, input logic [7:0] pix);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        req_sop   = s;
        req_eop   = e;
        for (int k = 0; k < NR; k++) req_data[k*PW +: PW] = 30'(k * 256 + int'(pix));
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t vv;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_sop   = '0;
        req_eop   = '0;
        req_data  = '0;

        // Reset state
        addVec(4'h0,4'h0,4'h0,8'h00, 4'h0,0,0,0,30'h0, 4'h0,0,0,0,30'h0, 0,0);
        // Req0 and req3 alternate single-beat packets, starting with req0
        addVec(4'b1001,4'b1001,4'b1001,8'h20, 4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);
        addVec(4'b1001,4'b1001,4'b1001,8'h21, 4'b0001,1,1,1,30'h021, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b1001,4'b1001,4'b1001,8'h22, 4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b1001,4'b1001,4'b1001,8'h23, 4'b1000,1,1,1,30'h323, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b1001,4'b1001,4'b1001,8'h24, 4'b0000,0,0,0,30'h0,   4'b0001,1,1,0,30'h021, 0,1);
        addVec(4'b1001,4'b1001,4'b1001,8'h25, 4'b0001,1,1,1,30'h025, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b1001,4'b1001,4'b1001,8'h26, 4'b0000,0,0,0,30'h0,   4'b1000,1,1,3,30'h323, 0,1);
        addVec(4'b1001,4'b1001,4'b1001,8'h27, 4'b1000,1,1,1,30'h327, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0001,1,1,0,30'h025, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b1000,1,1,3,30'h327, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);
        // Req0 four-beat packet 1..4
        addVec(4'b0001,4'b0001,4'b0000,8'h01, 4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);
        addVec(4'b0001,4'b0001,4'b0000,8'h01, 4'b0001,1,1,0,30'h001, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0001,4'b0000,4'b0000,8'h02, 4'b0001,1,0,0,30'h002, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0001,4'b0000,4'b0000,8'h03, 4'b0001,1,0,0,30'h003, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0001,4'b0000,4'b0001,8'h04, 4'b0001,1,0,1,30'h004, 4'b0001,1,0,0,30'h001, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0001,0,0,0,30'h002, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0001,0,0,0,30'h003, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0001,0,1,0,30'h004, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);
        // Req1 and req2 raise two-beat packets together: req1 first, no interleave
        addVec(4'b0110,4'b0110,4'b0000,8'h10, 4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);
        addVec(4'b0110,4'b0110,4'b0000,8'h10, 4'b0010,1,1,0,30'h110, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0110,4'b0100,4'b0010,8'h11, 4'b0010,1,0,1,30'h111, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0100,4'b0100,4'b0000,8'h11, 4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0100,4'b0100,4'b0000,8'h12, 4'b0100,1,1,0,30'h212, 4'b0010,1,0,1,30'h110, 0,1);
        addVec(4'b0100,4'b0000,4'b0100,8'h13, 4'b0100,1,0,1,30'h213, 4'b0010,0,1,1,30'h111, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0100,1,0,2,30'h212, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0100,0,1,2,30'h213, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);
        // Req2 packet with a 5-cycle gap while req0 waits
        addVec(4'b0100,4'b0100,4'b0000,8'h40, 4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);
        addVec(4'b0100,4'b0100,4'b0000,8'h40, 4'b0100,1,1,0,30'h240, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0001,4'b0001,4'b0001,8'h41, 4'b0100,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0001,4'b0001,4'b0001,8'h42, 4'b0100,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0001,4'b0001,4'b0001,8'h43, 4'b0100,0,0,0,30'h0,   4'b0100,1,0,2,30'h240, 0,1);
        addVec(4'b0001,4'b0001,4'b0001,8'h44, 4'b0100,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0001,4'b0001,4'b0001,8'h45, 4'b0100,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0101,4'b0001,4'b0101,8'h47, 4'b0100,1,0,1,30'h247, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0001,4'b0001,4'b0001,8'h48, 4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0001,4'b0001,4'b0001,8'h49, 4'b0001,1,1,1,30'h049, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0100,0,1,2,30'h247, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0001,1,1,0,30'h049, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);
        // Req1 first beat lacks sop: swallowed, flagged, rest forwarded
        addVec(4'b0010,4'b0000,4'b0000,8'h50, 4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);
        addVec(4'b0010,4'b0000,4'b0000,8'h51, 4'b0010,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   1,1);
        addVec(4'b0010,4'b0000,4'b0000,8'h52, 4'b0010,1,0,0,30'h152, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0010,4'b0000,4'b0000,8'h53, 4'b0010,1,0,0,30'h153, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'b0010,4'b0000,4'b0010,8'h54, 4'b0010,1,0,1,30'h154, 4'b0000,0,0,0,30'h0,   0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0010,0,0,1,30'h152, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0010,0,0,1,30'h153, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0010,0,1,1,30'h154, 0,1);
        addVec(4'h0,4'h0,4'h0,8'h00,          4'b0000,0,0,0,30'h0,   4'b0000,0,0,0,30'h0,   0,0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vv = vecs[i];
            applyStimulus(1'b0, vv.valid, vv.sop, vv.eop, vv.pix);
            @(negedge clk);
            checkOutput($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vv.expReady));
            checkOutput($sformatf("v%0d dp_in_valid", i), 32'(dp_in_valid), 32'(vv.expDpv));
            if (vv.expDpv) begin
                checkOutput($sformatf("v%0d dp_in_data", i), 32'(dp_in_data), 32'(vv.expDpData));
                checkOutput($sformatf("v%0d dp_in_sop", i), 32'(dp_in_sop), 32'(vv.expDps));
                checkOutput($sformatf("v%0d dp_in_eop", i), 32'(dp_in_eop), 32'(vv.expDpe));
            end
            checkOutput($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vv.expOutV));
            checkOutput($sformatf("v%0d out_sop", i), 32'(out_sop), 32'(vv.expOutSop));
            checkOutput($sformatf("v%0d out_eop", i), 32'(out_eop), 32'(vv.expOutEop));
            if (vv.expOutV != 4'h0) begin
                checkOutput($sformatf("v%0d out_id", i), 32'(out_id), 32'(vv.expOutId));
                checkOutput($sformatf("v%0d out_data", i), 32'(out_data), 32'(vv.expOutData));
            end
            checkOutput($sformatf("v%0d sop_err", i), 32'(sop_err), 32'(vv.expSopErr));
            checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'(vv.expBusy));
        end

        // Reset for one cycle with two beats of a req2 packet in flight
        applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0000, 8'h60);
        applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0000, 8'h60);
        @(negedge clk);
        checkOutput("rst pre dp_in_valid", 32'(dp_in_valid), 32'd1);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0000, 8'h61);
        applyStimulus(1'b1, 4'b0100, 4'b0000, 4'b0000, 8'h62);
        applyStimulus(1'b0, 4'b0101, 4'b0001, 4'b0001, 8'h64);
        @(negedge clk);
        checkOutput("rst idle req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst idle busy", 32'(busy), 32'h0);
        checkOutput("rst flush out_valid a", 32'(out_valid), 32'h0);
        checkOutput("rst idle sop_err", 32'(sop_err), 32'h0);
        applyStimulus(1'b0, 4'b0101, 4'b0001, 4'b0001, 8'h65);
        @(negedge clk);
        checkOutput("rst regrant req_ready", 32'(req_ready), 32'b0001);
        checkOutput("rst regrant dp_in_data", 32'(dp_in_data), 32'h065);
        checkOutput("rst flush out_valid b", 32'(out_valid), 32'h0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
        @(negedge clk);
        checkOutput("rst flush out_valid c", 32'(out_valid), 32'h0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
        @(negedge clk);
        checkOutput("rst regrant out_valid", 32'(out_valid), 32'b0001);
        checkOutput("rst regrant out_data", 32'(out_data), 32'h065);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
